// File: rtl/word_to_bytes_fifo.sv
// Word-to-UART byte serializer with a one-word pending buffer.
// A word is split into bytes (configurable order, optional EOT trailer) and
// each byte is handed to the UART with a tx_start / tx_done_tick handshake.
// A second word arriving mid-transmission waits in the pending buffer, so
// back-to-back words stream without returning to IDLE. A further word is
// dropped and flagged in the sticky overflow bit.
module word_to_bytes_fifo #(
    parameter int         WORD_BYTES = 4,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter bit         APPEND_EOT = 1'b0,
    parameter logic [7:0] EOT_CHAR   = 8'h04
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    word_ready,
    input  logic [8*WORD_BYTES-1:0] data_in,
    input  logic                    tx_busy,
    input  logic                    tx_done_tick,
    output logic                    tx_start,
    output logic [7:0]              data_out,
    output logic                    sending_word,
    output logic                    pending_full,
    output logic                    overflow
);

    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_DONE,
        EOT_ARM,
        EOT_WAIT
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [WORD_BYTES-1:0][7:0]     shift_q, shift_d;
    logic [WORD_BYTES-1:0][7:0]     pend_q, pend_d;
    logic                           pend_full_q, pend_full_d;
    logic                           ovf_q, ovf_d;
    logic                           tx_start_q, tx_start_d;
    logic [7:0]                     data_out_q, data_out_d;
    logic                           sending_q, sending_d;

    logic [CW-1:0]                  sel_idx;
    logic [7:0]                     sel_byte;
    logic                           eow;

    // Pick the byte addressed by the counter; plain index mux, no data arithmetic.
    always_comb begin
        sel_idx  = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
        sel_byte = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (sel_idx == CW'(i)) sel_byte = shift_q[i];
        end
    end

    // Next-state logic: handshake FSM, end-of-word hand-off and pending buffer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        ovf_d       = ovf_q;
        tx_start_d  = 1'b0;
        data_out_d  = data_out_q;
        sending_d   = sending_q;
        eow         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (word_ready) begin
                    shift_d   = data_in;
                    cnt_d     = '0;
                    sending_d = 1'b1;
                    state_d   = ARM;
                end
            end
            ARM: begin
                // data_out settles here and is frozen once tx_start fires
                data_out_d = sel_byte;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (cnt_q != LAST) begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ARM;
                    end else if (APPEND_EOT) begin
                        state_d = EOT_ARM;
                    end else begin
                        eow = 1'b1;
                    end
                end
            end
            EOT_ARM: begin
                data_out_d = EOT_CHAR;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = EOT_WAIT;
                end
            end
            EOT_WAIT: begin
                if (tx_done_tick) eow = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (eow) begin
            // End of word: the pending word goes first; a word arriving in this
            // very cycle takes the freed slot, so nothing is dropped here.
            if (pend_full_q) begin
                shift_d = pend_q;
                cnt_d   = '0;
                state_d = ARM;
                if (word_ready) pend_d = data_in;
                else            pend_full_d = 1'b0;
            end else if (word_ready) begin
                shift_d = data_in;
                cnt_d   = '0;
                state_d = ARM;
            end else begin
                state_d   = IDLE;
                sending_d = 1'b0;
            end
        end else if (word_ready && (state_q != IDLE)) begin
            if (!pend_full_q) begin
                pend_d      = data_in;
                pend_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            data_out_q  <= 8'h00;
            sending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ovf_q       <= ovf_d;
            tx_start_q  <= tx_start_d;
            data_out_q  <= data_out_d;
            sending_q   <= sending_d;
        end
    end

    assign tx_start     = tx_start_q;
    assign data_out     = data_out_q;
    assign sending_word = sending_q;
    assign pending_full = pend_full_q;
    assign overflow     = ovf_q;

endmodule
